// File: rtl/mc_controlunit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB over a
// req/ready memory handshake, resolves branches from ALU flags, and traps on faults.
module mc_controlunit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        memrw,
  output logic        ir_we,
  output logic        pc_we,
  output logic        regrw,
  output logic [1:0]  pcsrc,
  output logic [2:0]  imm_sel,
  output logic        alusrc,
  output logic [3:0]  aluop,
  output logic [1:0]  wb,
  output logic        trap,
  output logic [1:0]  cause
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI
  } cls_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;

  cls_t       cls;
  logic [2:0] dec_imm;
  logic       dec_alusrc;
  logic [3:0] dec_aluop;
  logic       taken;
  logic       timeout_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? 4'd1 : 4'd0;
      3'b001:  return 4'd2;
      3'b010:  return 4'd3;
      3'b011:  return 4'd4;
      3'b100:  return 4'd5;
      3'b101:  return alt ? 4'd7 : 4'd6;
      3'b110:  return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  always_comb begin
    cls        = C_ILL;
    dec_imm    = 3'd0;
    dec_alusrc = 1'b0;
    dec_aluop  = 4'd0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          cls       = C_ALU_R;
          dec_aluop = alu_of(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          cls       = C_ALU_R;
          dec_aluop = alu_of(funct3, 1'b1);
        end
      end
      7'b0010011: begin
        dec_alusrc = 1'b1;
        // Shift-immediates reuse funct7 as an opcode extension; other I-ops do not.
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0000000) begin
            cls       = C_ALU_I;
            dec_aluop = 4'd2;
          end
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000) begin
            cls       = C_ALU_I;
            dec_aluop = 4'd6;
          end else if (funct7 == 7'b0100000) begin
            cls       = C_ALU_I;
            dec_aluop = 4'd7;
          end
        end else begin
          cls       = C_ALU_I;
          dec_aluop = alu_of(funct3, 1'b0);
        end
      end
      7'b0000011: begin
        if (funct3 == 3'b010) cls = C_LOAD;
        dec_alusrc = 1'b1;
      end
      7'b0100011: begin
        if (funct3 == 3'b010) cls = C_STORE;
        dec_imm    = 3'd1;
        dec_alusrc = 1'b1;
      end
      7'b1100011: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) cls = C_BRANCH;
        dec_imm   = 3'd2;
        dec_aluop = 4'd1;
      end
      7'b1101111: begin
        cls     = C_JAL;
        dec_imm = 3'd3;
      end
      7'b1100111: begin
        if (funct3 == 3'b000) cls = C_JALR;
        dec_alusrc = 1'b1;
      end
      7'b0110111: begin
        cls     = C_LUI;
        dec_imm = 3'd4;
      end
      default: cls = C_ILL;
    endcase
    if (cls == C_ILL) begin
      dec_imm    = 3'd0;
      dec_alusrc = 1'b0;
      dec_aluop  = 4'd0;
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    memrw    = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    regrw    = 1'b0;
    pcsrc    = 2'd0;
    imm_sel  = 3'd0;
    alusrc   = 1'b0;
    aluop    = 4'd0;
    wb       = 2'd0;
    trap     = trap_q;
    cause    = cause_q;

    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      imm_sel = dec_imm;
      alusrc  = dec_alusrc;
      aluop   = dec_aluop;
    end

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_BRANCH: begin
            pc_we   = 1'b1;
            pcsrc   = taken ? 2'd1 : 2'd0;
            state_d = S_FETCH;
            cnt_d   = '0;
          end
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        memrw    = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
            cnt_d   = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        regrw   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        cnt_d   = '0;
        case (cls)
          C_LOAD: wb = 2'd1;
          C_JAL: begin
            wb    = 2'd2;
            pcsrc = 2'd1;
          end
          C_JALR: begin
            wb    = 2'd2;
            pcsrc = 2'd2;
          end
          C_LUI:   wb = 2'd3;
          default: wb = 2'd0;
        endcase
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Reset silences every output in the cycle it is sampled, aborting any write.
    if (rst) begin
      state_d  = S_FETCH;
      cnt_d    = '0;
      trap_d   = 1'b0;
      cause_d  = 2'd0;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      memrw    = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      regrw    = 1'b0;
      pcsrc    = 2'd0;
      imm_sel  = 3'd0;
      alusrc   = 1'b0;
      aluop    = 4'd0;
      wb       = 2'd0;
      trap     = 1'b0;
      cause    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_mc_controlunit.sv
// Directed bench for mc_controlunit: per-cycle expected output vectors are queued
// as stimulus is applied and popped/compared at the following negative edge.
module tb_mc_controlunit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero, lt, ltu;
  logic        imem_ready, dmem_ready;
  logic        imem_req, dmem_req, memrw, ir_we, pc_we, regrw;
  logic [1:0]  pcsrc;
  logic [2:0]  imm_sel;
  logic        alusrc;
  logic [3:0]  aluop;
  logic [1:0]  wb;
  logic        trap;
  logic [1:0]  cause;

  always #5 clk = ~clk;

  mc_controlunit #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .memrw(memrw), .ir_we(ir_we),
    .pc_we(pc_we), .regrw(regrw), .pcsrc(pcsrc), .imm_sel(imm_sel),
    .alusrc(alusrc), .aluop(aluop), .wb(wb), .trap(trap), .cause(cause)
  );

  // Order: imem_req dmem_req memrw ir_we pc_we regrw pcsrc imm_sel alusrc aluop wb trap cause
  typedef logic [20:0] ovec_t;
  ovec_t got;
  assign got = {imem_req, dmem_req, memrw, ir_we, pc_we, regrw, pcsrc, imm_sel,
                alusrc, aluop, wb, trap, cause};

  ovec_t exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic ovec_t o(input logic im, input logic dm, input logic rw,
                              input logic irw, input logic pcw, input logic rgw,
                              input logic [1:0] pcs, input logic [2:0] ims,
                              input logic asrc, input logic [3:0] aop,
                              input logic [1:0] wbs, input logic tr,
                              input logic [1:0] cs);
    return {im, dm, rw, irw, pcw, rgw, pcs, ims, asrc, aop, wbs, tr, cs};
  endfunction

  task automatic step(input string tag, input ovec_t e);
    ovec_t ex;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    ex = exp_q.pop_front();
    t  = tag_q.pop_front();
    n_tests++;
    assert (got === ex) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", t, got, ex);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] ins);
    instr      = ins;
    imem_ready = 1'b1;
    step(tag, o(1,0,0,1,0,0,2'd0,3'd0,0,4'd0,2'd0,0,2'd0));
    imem_ready = 1'b0;
  endtask

  initial begin
    ovec_t fw, zv;
    fw = o(1,0,0,0,0,0,2'd0,3'd0,0,4'd0,2'd0,0,2'd0);
    zv = '0;
    rst = 1'b1; instr = '0; zero = 0; lt = 0; ltu = 0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    @(posedge clk); #1;
    step("rst_outputs", zv);
    step("rst_outputs2", zv);
    rst = 1'b0; imem_ready = 1'b0;
    step("first_fetch", fw);

    // addi a3,a0,4 ; stray dmem_ready in DECODE must be ignored
    fetch("addi_fetch", 32'h00450693);
    dmem_ready = 1'b1;
    step("addi_dec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    dmem_ready = 1'b0;
    step("addi_exec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    step("addi_wb", o(0,0,0,0,1,1,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    step("addi_cycle5", fw);

    // bltu taken, flags only matter in EXEC
    fetch("bltu_t_fetch", 32'h00b76463);
    ltu = 0;
    step("bltu_t_dec", o(0,0,0,0,0,0,2'd0,3'd2,0,4'd1,2'd0,0,2'd0));
    ltu = 1;
    step("bltu_t_exec", o(0,0,0,0,1,0,2'd1,3'd2,0,4'd1,2'd0,0,2'd0));
    step("bltu_t_back", fw);
    // bltu not taken
    fetch("bltu_n_fetch", 32'h00b76463);
    ltu = 1;
    step("bltu_n_dec", o(0,0,0,0,0,0,2'd0,3'd2,0,4'd1,2'd0,0,2'd0));
    ltu = 0;
    step("bltu_n_exec", o(0,0,0,0,1,0,2'd0,3'd2,0,4'd1,2'd0,0,2'd0));
    // bge with lt=1 not taken ; beq with zero=1 taken
    fetch("bge_fetch", 32'h00005063);
    step("bge_dec", o(0,0,0,0,0,0,2'd0,3'd2,0,4'd1,2'd0,0,2'd0));
    lt = 1;
    step("bge_exec", o(0,0,0,0,1,0,2'd0,3'd2,0,4'd1,2'd0,0,2'd0));
    lt = 0;
    fetch("beq_fetch", 32'h00000063);
    step("beq_dec", o(0,0,0,0,0,0,2'd0,3'd2,0,4'd1,2'd0,0,2'd0));
    zero = 1;
    step("beq_exec", o(0,0,0,0,1,0,2'd1,3'd2,0,4'd1,2'd0,0,2'd0));
    zero = 0;

    // lw with dmem_ready delayed 3 cycles
    fetch("lw_fetch", 32'h0006a803);
    step("lw_dec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    step("lw_exec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", o(0,1,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    dmem_ready = 1'b1;
    step("lw_mem_ready", o(0,1,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    dmem_ready = 1'b0;
    step("lw_wb", o(0,0,0,0,1,1,2'd0,3'd0,1,4'd0,2'd1,0,2'd0));

    // sw
    fetch("sw_fetch", 32'h00d6a023);
    step("sw_dec", o(0,0,0,0,0,0,2'd0,3'd1,1,4'd0,2'd0,0,2'd0));
    step("sw_exec", o(0,0,0,0,0,0,2'd0,3'd1,1,4'd0,2'd0,0,2'd0));
    dmem_ready = 1'b1;
    step("sw_mem", o(0,1,1,0,1,0,2'd0,3'd1,1,4'd0,2'd0,0,2'd0));
    dmem_ready = 1'b0;
    step("sw_back", fw);

    // jalr, jal, lui, sra, srai
    fetch("jalr_fetch", 32'h00008067);
    step("jalr_dec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    step("jalr_exec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    step("jalr_wb", o(0,0,0,0,1,1,2'd2,3'd0,1,4'd0,2'd2,0,2'd0));
    fetch("jal_fetch", 32'h0000006f);
    step("jal_dec", o(0,0,0,0,0,0,2'd0,3'd3,0,4'd0,2'd0,0,2'd0));
    step("jal_exec", o(0,0,0,0,0,0,2'd0,3'd3,0,4'd0,2'd0,0,2'd0));
    step("jal_wb", o(0,0,0,0,1,1,2'd1,3'd3,0,4'd0,2'd2,0,2'd0));
    fetch("lui_fetch", 32'h000002b7);
    step("lui_dec", o(0,0,0,0,0,0,2'd0,3'd4,0,4'd0,2'd0,0,2'd0));
    step("lui_exec", o(0,0,0,0,0,0,2'd0,3'd4,0,4'd0,2'd0,0,2'd0));
    step("lui_wb", o(0,0,0,0,1,1,2'd0,3'd4,0,4'd0,2'd3,0,2'd0));
    fetch("sra_fetch", 32'h40005033);
    step("sra_dec", o(0,0,0,0,0,0,2'd0,3'd0,0,4'd7,2'd0,0,2'd0));
    step("sra_exec", o(0,0,0,0,0,0,2'd0,3'd0,0,4'd7,2'd0,0,2'd0));
    step("sra_wb", o(0,0,0,0,1,1,2'd0,3'd0,0,4'd7,2'd0,0,2'd0));
    fetch("srai_fetch", 32'h40005013);
    step("srai_dec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd7,2'd0,0,2'd0));
    step("srai_exec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd7,2'd0,0,2'd0));
    step("srai_wb", o(0,0,0,0,1,1,2'd0,3'd0,1,4'd7,2'd0,0,2'd0));

    // Ready on the 16th request cycle still wins over the timeout
    for (int i = 0; i < 15; i++) step("fetch_slow", fw);
    fetch("fetch_ready16", 32'h00450693);
    step("slow_dec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    step("slow_exec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    step("slow_wb", o(0,0,0,0,1,1,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));

    // Illegal instruction 00000000 -> TRAP cause 1, sticky until rst
    fetch("ill_fetch", 32'h00000000);
    step("ill_dec", zv);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("ill_trap", o(0,0,0,0,0,0,2'd0,3'd0,0,4'd0,2'd0,1,2'd1));
    imem_ready = 1'b0; dmem_ready = 1'b0;
    rst = 1'b1;
    step("ill_rst", zv);
    rst = 1'b0;
    // slli with funct7=0100000 is illegal
    fetch("slli_bad_fetch", 32'h40001013);
    step("slli_bad_dec", zv);
    step("slli_bad_trap", o(0,0,0,0,0,0,2'd0,3'd0,0,4'd0,2'd0,1,2'd1));
    rst = 1'b1;
    step("slli_bad_rst", zv);
    rst = 1'b0;

    // rst in EXEC of a taken branch suppresses pc_we
    fetch("rstx_fetch", 32'h00b76463);
    step("rstx_dec", o(0,0,0,0,0,0,2'd0,3'd2,0,4'd1,2'd0,0,2'd0));
    ltu = 1; rst = 1'b1;
    step("rstx_exec", zv);
    ltu = 0; rst = 1'b0;
    step("rstx_refetch", fw);
    rst = 1'b1;
    step("rstx_rst2", zv);
    rst = 1'b0;

    // imem_ready held 0: 16 request cycles then TRAP cause 2
    for (int i = 0; i < 16; i++) step("imem_to_req", fw);
    imem_ready = 1'b1;
    step("imem_to_trap", o(0,0,0,0,0,0,2'd0,3'd0,0,4'd0,2'd0,1,2'd2));
    step("imem_to_hold", o(0,0,0,0,0,0,2'd0,3'd0,0,4'd0,2'd0,1,2'd2));
    imem_ready = 1'b0;
    rst = 1'b1;
    step("imem_to_rst", zv);
    rst = 1'b0;

    // dmem timeout during a load
    fetch("dto_fetch", 32'h0006a803);
    step("dto_dec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    step("dto_exec", o(0,0,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    for (int i = 0; i < 16; i++) step("dto_req", o(0,1,0,0,0,0,2'd0,3'd0,1,4'd0,2'd0,0,2'd0));
    step("dto_trap", o(0,0,0,0,0,0,2'd0,3'd0,0,4'd0,2'd0,1,2'd2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
